// File: rtl/aux_run_sequencer_if.sv
// Run-control bundle between the board/core side and the run sequencer.
// Inputs: resume/step buttons (raw), budget, halt, pc, bp_addr.
// Outputs: en, state, run_cnt, stop_cause; master = sequencer side.
interface aux_run_sequencer_if #(
  parameter int CntBit = 32
);
  logic              resume;
  logic              step;
  logic [CntBit-1:0] budget;
  logic              halt;
  logic [31:0]       pc;
  logic [31:0]       bp_addr;
  logic              en;
  logic [1:0]        state;
  logic [CntBit-1:0] run_cnt;
  logic [1:0]        stop_cause;

  modport master (
    input  resume, step, budget, halt, pc, bp_addr,
    output en, state, run_cnt, stop_cause
  );

  modport slave (
    output resume, step, budget, halt, pc, bp_addr,
    input  en, state, run_cnt, stop_cause
  );
endinterface

// File: rtl/aux_run_sequencer.sv
// Run-control sequencer: debounced resume/step buttons drive the core enable.
// Latency: press to state change is 3 + DebounceCnt cycles; en is a pure state decode.
// Backpressure: none; halt/breakpoint/budget stop the core after the current cycle.
// Ports: clk, rst (async active-high), bus (aux_run_sequencer_if.master).
// Optional feature: define AUX_SEQ_BREAKPOINT_EN to stop RUN on pc == bp_addr.
module aux_run_sequencer #(
  parameter int DebounceCnt = 16,
  parameter int CntBit      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  aux_run_sequencer_if.master   bus
);

  localparam int DbW = $clog2(DebounceCnt + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    STEP    = 2'b10,
    STOPPED = 2'b11
  } state_t;

  // Button paths, bit 0 = resume, bit 1 = step.
  logic [1:0]          sync1, sync2, deb, pulse;
  logic [1:0][DbW-1:0] db_cnt;
  logic                rp, sp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      deb    <= '0;
      pulse  <= '0;
      db_cnt <= '0;
    end else begin
      sync1 <= {bus.step, bus.resume};
      sync2 <= sync1;
      pulse <= '0;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DbW'(DebounceCnt)) begin
          deb[i]    <= ~deb[i];
          db_cnt[i] <= '0;
          // Pulse only on the rising flip; it is high in the cycle the level rises.
          pulse[i]  <= ~deb[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DbW'(1);
        end
      end
    end
  end

  assign rp = pulse[0];
  assign sp = pulse[1];

  state_t            state_q, state_d;
  logic [CntBit-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]        cause_q, cause_d;
  logic              bp_hit;

  assign cnt_inc = cnt_q + CntBit'(1);

`ifdef AUX_SEQ_BREAKPOINT_EN
  // first_q marks the first RUN cycle of a segment so a resume from a
  // breakpoint steps past the matching pc instead of re-stopping on it.
  logic first_q;

  assign bp_hit = ~first_q & (bus.pc == bus.bp_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) first_q <= 1'b0;
    else     first_q <= (state_d == RUN) && (state_q != RUN);
  end
`else
  logic unused_bp;
  assign unused_bp = ^{bus.pc, bus.bp_addr};
  assign bp_hit    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cause_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: begin
        if (rp) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (sp) begin
          state_d = STEP;
        end
      end
      RUN: begin
        cnt_d = cnt_inc;
        // A passed budget (wrap or late change) never equals cnt_inc again
        // before wrapping, so it is simply not hit in this segment.
        if (bus.halt) begin
          state_d = STOPPED;
          cause_d = 2'd1;
        end else if (bp_hit) begin
          state_d = STOPPED;
          cause_d = 2'd3;
        end else if ((bus.budget != '0) && (cnt_inc == bus.budget)) begin
          state_d = STOPPED;
          cause_d = 2'd2;
        end else if (rp) begin
          state_d = STOPPED;
          cause_d = 2'd0;
        end
      end
      STEP: begin
        cnt_d   = cnt_inc;
        state_d = STOPPED;
        cause_d = bus.halt ? 2'd1 : 2'd0;
      end
      STOPPED: begin
        if (rp) begin
          state_d = RUN;
          cnt_d   = '0;
          cause_d = 2'd0;
        end else if (sp) begin
          state_d = STEP;
          cause_d = 2'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.en         = (state_q == RUN) | (state_q == STEP);
  assign bus.state      = state_q;
  assign bus.run_cnt    = cnt_q;
  assign bus.stop_cause = cause_q;

endmodule

// File: tb/tb_aux_run_sequencer.sv
// Directed bench for aux_run_sequencer with DebounceCnt=4.
// Inputs change just after a falling edge; outputs are sampled on falling edges.
// Press set after falling edge k=0 puts the sequencer in RUN/STEP at falling edge k=8.
module tb_aux_run_sequencer;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  int   en_cnt;
  bit   found;

  aux_run_sequencer_if #(.CntBit(32)) bus ();

  aux_run_sequencer #(
    .DebounceCnt(4),
    .CntBit     (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bus.resume  = 1'b0;
    bus.step    = 1'b0;
    bus.budget  = 32'd5;
    bus.halt    = 1'b0;
    bus.pc      = 32'h0;
    bus.bp_addr = 32'h40;

    // Reset state
    tick(3);
    chk("rst_state", bus.state, 2'b00);
    chk("rst_en", bus.en, 1'b0);
    chk("rst_cnt", bus.run_cnt, 0);
    chk("rst_cause", bus.stop_cause, 0);
    rst = 1'b0;
    tick(2);

    // 3-cycle bounce: never reaches the debounce count
    bus.resume = 1'b1;
    tick(3);
    bus.resume = 1'b0;
    tick(10);
    chk("bounce_idle", bus.state, 2'b00);

    // 20-cycle press with budget 5
    en_cnt = 0;
    bus.resume = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick(1);
      if (k == 7) chk("press_k7_idle", bus.state, 2'b00);
      if (k == 8) begin
        chk("press_k8_run", bus.state, 2'b01);
        chk("press_k8_en", bus.en, 1'b1);
        chk("press_k8_cnt", bus.run_cnt, 0);
      end
      if (k == 13) chk("budget_k13_en", bus.en, 1'b0);
      if (k >= 8) en_cnt += int'(bus.en);
      if (k == 20) bus.resume = 1'b0;
    end
    chk("budget_en_cycles", en_cnt, 5);
    chk("budget_state", bus.state, 2'b11);
    chk("budget_cause", bus.stop_cause, 2);
    chk("budget_cnt", bus.run_cnt, 5);
    tick(10);
    chk("held_one_pulse", bus.state, 2'b11);

    // Resume with unlimited budget, then halt on run cycle 9
    bus.budget = 32'd0;
    bus.resume = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick(1);
      if (k == 8) begin
        chk("resume_run", bus.state, 2'b01);
        chk("resume_cnt_clr", bus.run_cnt, 0);
        chk("resume_cause_clr", bus.stop_cause, 0);
      end
      if (k == 10) bus.resume = 1'b0;
      if (k == 17) begin
        chk("halt_c9_cnt", bus.run_cnt, 9);
        chk("halt_c9_en", bus.en, 1'b1);
        bus.halt = 1'b1;
      end
      if (k == 18) begin
        chk("halt_c10_en", bus.en, 1'b0);
        chk("halt_state", bus.state, 2'b11);
        chk("halt_cause", bus.stop_cause, 1);
        chk("halt_cnt", bus.run_cnt, 10);
        bus.halt = 1'b0;
      end
    end
    tick(4);

    // Three single steps from STOPPED
    for (int i = 0; i < 3; i++) begin
      bus.step = 1'b1;
      tick(7);
      chk("step_pre", bus.state, 2'b11);
      tick(1);
      chk("step_state", bus.state, 2'b10);
      chk("step_en", bus.en, 1'b1);
      tick(1);
      chk("step_back", bus.state, 2'b11);
      chk("step_en_off", bus.en, 1'b0);
      chk("step_cnt", bus.run_cnt, 64'(11 + i));
      chk("step_cause", bus.stop_cause, 0);
      bus.step = 1'b0;
      tick(12);
    end

    // Resume and step pulses in the same cycle: RUN wins
    bus.resume = 1'b1;
    bus.step   = 1'b1;
    tick(7);
    chk("both_pre", bus.state, 2'b11);
    tick(1);
    chk("both_run", bus.state, 2'b01);
    chk("both_cnt", bus.run_cnt, 0);
    tick(1);
    bus.resume = 1'b0;
    bus.step   = 1'b0;
    tick(1);
    chk("both_cnt2", bus.run_cnt, 2);

    // Reset mid-run at run_cnt 123
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.run_cnt == 32'd123) begin
        found = 1'b1;
        break;
      end
      tick(1);
    end
    chk("reach_123", found, 1'b1);
    chk("pre_rst_en", bus.en, 1'b1);
    rst = 1'b1;
    #1;
    chk("arst_en", bus.en, 1'b0);
    chk("arst_state", bus.state, 2'b00);
    chk("arst_cnt", bus.run_cnt, 0);
    chk("arst_cause", bus.stop_cause, 0);
    tick(2);
    rst = 1'b0;
    tick(12);
    chk("post_rst_idle", bus.state, 2'b00);

`ifdef AUX_SEQ_BREAKPOINT_EN
    // Breakpoint at 0x40, then resume past it
    bus.pc     = 32'h0;
    bus.resume = 1'b1;
    tick(8);
    chk("bp_run", bus.state, 2'b01);
    bus.resume = 1'b0;
    tick(2);
    bus.pc = 32'h40;
    tick(1);
    chk("bp_stop_state", bus.state, 2'b11);
    chk("bp_cause", bus.stop_cause, 3);
    chk("bp_cnt", bus.run_cnt, 3);
    tick(10);
    bus.resume = 1'b1;
    tick(8);
    chk("bp_resume_run", bus.state, 2'b01);
    bus.pc     = 32'h44;
    bus.resume = 1'b0;
    tick(2);
    chk("bp_past_state", bus.state, 2'b01);
    chk("bp_past_cause", bus.stop_cause, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/aux_run_sequencer.md
# aux_run_sequencer

Run-control sequencer for the single-cycle core. It replaces a bare run/halt latch with a small state machine that generates the core enable (`en`) from two debounced board buttons, resume and step. It also counts enabled cycles, optionally stops after a cycle budget, and reports why the core stopped. It sits between the board inputs and the core/counter enables in the top level, on the core clock domain.

## Interface
- `DebounceCnt`, default 16: core-clock cycles a synchronized button level must hold before it is accepted.
- `CntBit`, default 32: width of the budget and of the run counter.
- `clk` in 1: core clock.
- `rst` in 1: asynchronous, active-high reset.
- `resume` in 1: raw resume button, asynchronous to `clk`.
- `step` in 1: raw single-step button, asynchronous to `clk`.
- `budget` in `CntBit`: cycle budget per run segment; 0 means unlimited.
- `halt` in 1: core halt indication, meaningful only while `en`=1.
- `pc` in 32: current core PC (used only with the breakpoint feature).
- `bp_addr` in 32: breakpoint address (used only with the breakpoint feature).
- `en` out 1: core enable.
- `state` out 2: IDLE=00, RUN=01, STEP=10, STOPPED=11.
- `run_cnt` out `CntBit`: number of enabled cycles in the current segment.
- `stop_cause` out 2: 0=none/pause, 1=halt, 2=budget, 3=breakpoint.

## Operation
- Reset values: `state`=IDLE, `en`=0, `run_cnt`=0, `stop_cause`=0. Synchronizers, debounced levels and debounce counters are all 0.
- Button path, per button:
  - Two-flop synchronizer.
  - Debounce counter: reset to 0 whenever the synchronized value equals the debounced level; otherwise increment. At `DebounceCnt` the debounced level flips and the counter clears.
  - A 0→1 transition of the debounced level yields a one-cycle pulse (`rp`, `sp`). Releases produce no pulse.
- `en` = (`state`==RUN) | (`state`==STEP), decoded from the state register with no combinational input path.
- IDLE:
  - `rp` → RUN, with `run_cnt` cleared.
  - `sp` → STEP.
  - `rp` and `sp` in the same cycle → RUN.
- RUN: every cycle `run_cnt` increments, wrapping at 2^CntBit. Exit conditions are evaluated in this priority order:
  1. `halt` → STOPPED, cause 1.
  2. Breakpoint hit (feature on) → STOPPED, cause 3.
  3. `budget`≠0 and `run_cnt`+1 == `budget` → STOPPED, cause 2.
  4. `rp` → STOPPED, cause 0 (pause).
  - `sp` is ignored in RUN.
- STEP: exactly one enabled cycle, `run_cnt` increments. Then → STOPPED with cause 1 if `halt`, else cause 0.
- STOPPED:
  - `rp` → RUN, `run_cnt` cleared, `stop_cause` cleared.
  - `sp` → STEP, `stop_cause` cleared, `run_cnt` kept.
  - `rp` and `sp` together → RUN.
- A stopped core resumes after any cause, including halt: the core re-samples its own halt condition.
- `budget` is sampled every RUN cycle; changing it mid-run takes effect immediately. A budget already passed, because of wrap or a late change, is never hit within that segment.

## Timing
- The instruction active in the cycle where `halt`, a breakpoint, or the budget is detected executes (`en`=1). `en` is 0 from the next cycle on.
- Stable press beginning before edge t: debounced level rises at edge t+2+`DebounceCnt`, the pulse is high in that cycle, `state`/`en` change at the following edge.
- A budget of N gives exactly N enabled cycles in the segment; `run_cnt`=N while STOPPED.
- Reset asserted mid-run: `en` drops asynchronously and every output returns to its reset value; no pulse is generated on release.
- A button held indefinitely produces exactly one pulse.

## Configuration
- `AUX_SEQ_BREAKPOINT_EN` defined:
  - In RUN, `pc`==`bp_addr` stops with cause 3.
  - The compare is suppressed on the first RUN cycle after entry, so resuming from a breakpoint advances past it.
  - STEP ignores breakpoints.
- Not defined: `pc` and `bp_addr` are unused, no comparator is built, and cause 3 never occurs.

## Test plan
All scenarios use `DebounceCnt`=4.
- Reset, then a 20-cycle `resume` press → one pulse, RUN 7 cycles after the press edge, `en`=1; the 3-cycle bounce before it yields no pulse.
- RUN with `budget`=5 → `en` high exactly 5 cycles, STOPPED, `stop_cause`=2, `run_cnt`=5; resume → `run_cnt` restarts from 0.
- STOPPED, three `step` presses → three single `en` pulses, `run_cnt` +3, `state` returns to STOPPED (11) each time.
- RUN, `halt`=1 on cycle 9 → `en`=0 from cycle 10, `stop_cause`=1; `resume` and `step` pulses in the same cycle from STOPPED → RUN.
- With `AUX_SEQ_BREAKPOINT_EN`, `bp_addr`=0x0000_0040, `pc` reaches 0x40 → stop with cause 3; resume while `pc` is still 0x40 → proceeds without re-stopping.
- Assert `rst` mid-RUN with `run_cnt`=123 → `en`=0 immediately, IDLE, `run_cnt`=0, `stop_cause`=0.
